// File: rtl/ita_disp_pkg.sv
// Shared types, widths and the ASCII -> 14-segment font for the ITA display tile.
// Segment bit order: 0 A, 1 B, 2 C, 3 D, 4 E, 5 F, 6 G1, 7 G2, 8 H, 9 J, 10 K, 11 L, 12 M, 13 N.
// Printable ASCII 0x20..0x7E has a glyph (lower case reuses upper case); anything else is blank.
package ita_disp_pkg;

    localparam int unsigned SEG_W      = 14;
    localparam int unsigned CHAR_W     = 7;
    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned IDX_W      = $clog2(MAX_DIGITS);

    localparam logic [SEG_W-1:0]  GLYPH_BLANK = 14'h0000;
    localparam logic [CHAR_W-1:0] CHAR_SPACE  = 7'h20;

    typedef enum logic {PH_BLANK, PH_DRIVE} slot_phase_e;

    function automatic logic [SEG_W-1:0] ascii_to_glyph(input logic [CHAR_W-1:0] ch);
        logic [CHAR_W-1:0] c;
        logic [SEG_W-1:0]  g;
        c = ((ch >= 7'h61) && (ch <= 7'h7A)) ? ch - 7'h20 : ch;
        case (c)
            7'h20: g = 14'h0000;  7'h21: g = 14'h0006;  7'h22: g = 14'h0220;
            7'h23: g = 14'h12CE;  7'h24: g = 14'h12ED;  7'h25: g = 14'h0C24;
            7'h26: g = 14'h235D;  7'h27: g = 14'h0400;  7'h28: g = 14'h2400;
            7'h29: g = 14'h0900;  7'h2A: g = 14'h3FC0;  7'h2B: g = 14'h12C0;
            7'h2C: g = 14'h0800;  7'h2D: g = 14'h00C0;  7'h2E: g = 14'h0800;
            7'h2F: g = 14'h0C00;  7'h30: g = 14'h0C3F;  7'h31: g = 14'h0006;
            7'h32: g = 14'h00DB;  7'h33: g = 14'h008F;  7'h34: g = 14'h00E6;
            7'h35: g = 14'h2069;  7'h36: g = 14'h00FD;  7'h37: g = 14'h0007;
            7'h38: g = 14'h00FF;  7'h39: g = 14'h00EF;  7'h3A: g = 14'h1200;
            7'h3B: g = 14'h0A00;  7'h3C: g = 14'h2400;  7'h3D: g = 14'h00C8;
            7'h3E: g = 14'h0900;  7'h3F: g = 14'h1083;  7'h40: g = 14'h02BB;
            7'h41: g = 14'h00F7;  7'h42: g = 14'h128F;  7'h43: g = 14'h0039;
            7'h44: g = 14'h120F;  7'h45: g = 14'h00F9;  7'h46: g = 14'h0071;
            7'h47: g = 14'h00BD;  7'h48: g = 14'h00F6;  7'h49: g = 14'h1209;
            7'h4A: g = 14'h001E;  7'h4B: g = 14'h2470;  7'h4C: g = 14'h0038;
            7'h4D: g = 14'h0536;  7'h4E: g = 14'h2136;  7'h4F: g = 14'h003F;
            7'h50: g = 14'h00F3;  7'h51: g = 14'h203F;  7'h52: g = 14'h20F3;
            7'h53: g = 14'h00ED;  7'h54: g = 14'h1201;  7'h55: g = 14'h003E;
            7'h56: g = 14'h0C30;  7'h57: g = 14'h2836;  7'h58: g = 14'h2D00;
            7'h59: g = 14'h1500;  7'h5A: g = 14'h0C09;  7'h5B: g = 14'h0039;
            7'h5C: g = 14'h2100;  7'h5D: g = 14'h000F;  7'h5E: g = 14'h0C03;
            7'h5F: g = 14'h0008;  7'h60: g = 14'h0100;  7'h7B: g = 14'h0949;
            7'h7C: g = 14'h1200;  7'h7D: g = 14'h2489;  7'h7E: g = 14'h0520;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ita_font_rom.sv
// Registered ASCII -> 14-segment glyph lookup (one cycle latency).
// Ports: clk, rst (async, active-high), ch (ASCII in), glyph (segment pattern out, blank in reset).
module ita_font_rom
    import ita_disp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] ch,
    output logic [SEG_W-1:0]  glyph
);

    logic [SEG_W-1:0] glyph_q, glyph_d;

    always_comb begin
        glyph_d = ascii_to_glyph(ch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glyph_q <= GLYPH_BLANK;
        end else begin
            glyph_q <= glyph_d;
        end
    end

    assign glyph = glyph_q;

endmodule

// File: rtl/ita_scan_driver.sv
// Time-multiplexed scan driver for one multi-digit 14-segment tile.
// Characters are written into a shadow buffer; a commit copies shadow -> active at the next frame
// wrap. Each digit slot starts with BLANK cycles of sel=0/segm=0 to hide ghosting and ROM latency.
// Ports: clk, rst (async, active-high); wr_valid/wr_ready/wr_addr/wr_char/wr_commit write side;
//        scroll_en (only with ITA_SCROLL_EN); sel (one-hot digit), segm (segments), frame_tick.
// Build option: define ITA_SCROLL_EN to add the scroll_en port and the marquee offset counter.
module ita_scan_driver
    import ita_disp_pkg::*;
#(
    parameter int unsigned DIGITS = 12,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned BLANK  = 8
`ifdef ITA_SCROLL_EN
    ,
    parameter int unsigned SCROLL_FRAMES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              wr_commit,
`ifdef ITA_SCROLL_EN
    input  logic              scroll_en,
`endif
    output logic [DIGITS-1:0] sel,
    output logic [SEG_W-1:0]  segm,
    output logic              frame_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pending_q, pending_d;
    logic              frame_tick_q;
    logic [CHAR_W-1:0] shadow_q [DIGITS];
    logic [CHAR_W-1:0] shadow_d [DIGITS];
    logic [CHAR_W-1:0] active_q [DIGITS];
    logic [CHAR_W-1:0] active_d [DIGITS];

    logic              slot_end, wrap, wr_fire, commit_fire;
    logic [IDX_W-1:0]  off, rd_idx;
    logic [IDX_W:0]    rd_sum;
    logic [SEG_W-1:0]  glyph;
    slot_phase_e       phase;

    always_comb begin
        slot_end = (cnt_q == CNT_W'(DIV - 1));
        wrap     = slot_end && (idx_q == IDX_W'(DIGITS - 1));
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        wr_fire     = wr_valid && !pending_q;
        commit_fire = wr_commit && !pending_q;

        // Out-of-range addresses still complete the handshake but store nothing.
        shadow_d = shadow_q;
        if (wr_fire && ({1'b0, wr_addr} < (IDX_W + 1)'(DIGITS))) begin
            shadow_d[wr_addr] = wr_char;
        end

        // Swap uses the registered pending flag, so a commit in the wrap cycle waits a frame.
        active_d  = active_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (commit_fire) begin
            pending_d = 1'b1;
        end

        rd_sum = {1'b0, idx_q} + {1'b0, off};
        if (rd_sum >= (IDX_W + 1)'(DIGITS)) begin
            rd_sum = rd_sum - (IDX_W + 1)'(DIGITS);
        end
        rd_idx = rd_sum[IDX_W-1:0];

        phase = (cnt_q < CNT_W'(BLANK)) ? PH_BLANK : PH_DRIVE;
        sel   = '0;
        segm  = GLYPH_BLANK;
        if (phase == PH_DRIVE) begin
            sel  = DIGITS'(1) << idx_q;
            segm = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= CHAR_SPACE;
                active_q[i] <= CHAR_SPACE;
            end
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_tick_q <= wrap;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    // Looked up every cycle; the value seen after blanking comes from the slot's own digit.
    ita_font_rom u_font_rom (
        .clk   (clk),
        .rst   (rst),
        .ch    (active_q[rd_idx]),
        .glyph (glyph)
    );

`ifdef ITA_SCROLL_EN
    localparam int unsigned FCNT_W = $clog2(SCROLL_FRAMES + 1);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [IDX_W-1:0]  off_q, off_d;
    logic              step;

    always_comb begin
        fcnt_d = fcnt_q;
        off_d  = off_q;
        step   = 1'b0;
        if (wrap && scroll_en) begin
            step   = (fcnt_q == FCNT_W'(SCROLL_FRAMES - 1));
            fcnt_d = step ? '0 : fcnt_q + 1'b1;
        end
        // New text always starts unscrolled.
        if (wrap && pending_q) begin
            off_d = '0;
        end else if (step) begin
            off_d = (off_q == IDX_W'(DIGITS - 1)) ? '0 : off_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
            off_q  <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            off_q  <= off_d;
        end
    end

    assign off = off_q;
`else
    assign off = '0;
`endif

    assign wr_ready   = !pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ita_scan_driver.sv
// Self-checking bench for ita_scan_driver (DIGITS=12, DIV=4, BLANK=1, SCROLL_FRAMES=2).
// Expected outputs come from a frame-level model: slot position is derived from the cycle count
// since reset, and buffer/pending/offset state changes only on handshakes and frame wraps.
module tb_ita_scan_driver;

    localparam int unsigned DIGITS = 12;
    localparam int unsigned DIV    = 4;
    localparam int unsigned BLANK  = 1;
    localparam int unsigned SF     = 2;
    localparam int unsigned FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_commit = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [6:0]  wr_char = '0;
    logic        wr_ready;
    logic        frame_tick;
    logic [11:0] sel;
    logic [13:0] segm;
`ifdef ITA_SCROLL_EN
    logic        scroll_en = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned t;
    int          m_shadow [DIGITS];
    int          m_active [DIGITS];
    bit          m_pending;
    int          m_off;
    int          m_fc;
    bit          m_ftick;

    ita_scan_driver #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK)
`ifdef ITA_SCROLL_EN
        ,
        .SCROLL_FRAMES (SF)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .wr_commit  (wr_commit),
`ifdef ITA_SCROLL_EN
        .scroll_en  (scroll_en),
`endif
        .sel        (sel),
        .segm       (segm),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Independent glyph table for the characters the stimulus uses.
    function automatic logic [13:0] font(input int c);
        logic [13:0] g;
        case (c)
            'h30:       g = 14'h0C3F;
            'h37:       g = 14'h0007;
            'h41, 'h61: g = 14'h00F7;
            'h48:       g = 14'h00F6;
            default:    g = 14'h0000;
        endcase
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        m_pending = 1'b0;
        m_off     = 0;
        m_fc      = 0;
        m_ftick   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            m_shadow[i] = 'h20;
            m_active[i] = 'h20;
        end
    endtask

    task automatic check_outputs();
        int          cnt;
        int          idx;
        logic [11:0] es;
        logic [13:0] eg;
        cnt = int'(t % DIV);
        idx = int'((t / DIV) % DIGITS);
        es  = '0;
        eg  = '0;
        if (cnt >= BLANK) begin
            es = 12'(1 << idx);
            eg = font(m_active[(idx + m_off) % DIGITS]);
        end
        chk("sel", {20'b0, sel}, {20'b0, es});
        chk("segm", {18'b0, segm}, {18'b0, eg});
        chk("frame_tick", {31'b0, frame_tick}, {31'b0, m_ftick});
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, !m_pending});
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit wrap;
        bit ready;
        bit v;
        bit cm;
        int a;
        int ch;
        bit step;
        wrap  = ((t % FRAME) == FRAME - 1);
        ready = !m_pending;
        v     = wr_valid;
        cm    = wr_commit;
        a     = int'(wr_addr);
        ch    = int'(wr_char);
        step  = 1'b0;
        @(posedge clk);
        if (ready && v && (a < DIGITS)) m_shadow[a] = ch;
`ifdef ITA_SCROLL_EN
        if (wrap && scroll_en) begin
            m_fc++;
            if (m_fc == SF) begin
                m_fc = 0;
                step = 1'b1;
            end
        end
        if (wrap && m_pending) m_off = 0;
        else if (step) m_off = (m_off + 1) % DIGITS;
`endif
        if (wrap && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (ready && cm) begin
            m_pending = 1'b1;
        end
        m_ftick = wrap;
        t++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold the request until the handshake fires; bounded.
    task automatic write(input bit v, input int addr, input int ch, input bit commit);
        bit fired;
        fired     = 1'b0;
        wr_valid  = v;
        wr_addr   = addr[3:0];
        wr_char   = ch[6:0];
        wr_commit = commit;
        for (int i = 0; i < 4 * FRAME && !fired; i++) begin
            fired = !m_pending;
            tick();
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        chk("wr_handshake", {31'b0, fired}, 32'd1);
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_sel", {20'b0, sel}, 32'd0);
        chk("rst_segm", {18'b0, segm}, 32'd0);
        chk("rst_ftick", {31'b0, frame_tick}, 32'd0);
        chk("rst_ready", {31'b0, wr_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    initial begin
        int chars [8];
        chars = '{'h20, 'h30, 'h41, 'h61, 'h37, 'h48, 'h05, 'h7F};

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();

        // Idle scan: blank then walking select, segm stays blank.
        idle(50);

        // '0' at digit 3, committed mid-frame.
        idle(20);
        write(1'b1, 3, 'h30, 1'b1);
        idle(2 * FRAME);

        // Out-of-range addresses handshake but change nothing.
        write(1'b1, 12, 'h41, 1'b0);
        write(1'b1, 15, 'h41, 1'b0);
        write(1'b0, 0, 0, 1'b1);
        idle(2 * FRAME);

        // Write+commit exactly in the wrap cycle: swap one frame later.
        while ((t % FRAME) != FRAME - 1) tick();
        write(1'b1, 5, 'h48, 1'b1);
        idle(2 * FRAME + 4);

        // Reset mid-slot with a commit pending.
        idle(6);
        write(1'b1, 7, 'h37, 1'b1);
        idle(3);
        async_reset();
        idle(FRAME + 10);

        // Random writes and commits.
        for (int k = 0; k < 40; k++) begin
            write(1'b1, int'($urandom_range(0, 15)), chars[$urandom_range(0, 7)],
                  $urandom_range(0, 3) == 0);
            idle(int'($urandom_range(0, 30)));
        end
        write(1'b0, 0, 0, 1'b1);
        idle(2 * FRAME);

`ifdef ITA_SCROLL_EN
        // Marquee: 'A' at digit 0 moves down one digit every two frames.
        async_reset();
        write(1'b1, 0, 'h41, 1'b1);
        idle(2 * FRAME);
        scroll_en = 1'b1;
        idle(10 * FRAME);
        scroll_en = 1'b0;
        idle(2 * FRAME);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
